mux41_rr_arbiter: RTL and testbench
===================================

// Module: mux41_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 mux (m41) between four requesters.
//  Requester k (0..3) maps to mux data input a/b/c/d. The arbiter drives the mux selects s1:s0 directly.
//  A grant is held until the owner signals done, drops its request, or hits a hold-time limit.
//  There is one dead (no-grant) cycle between owners, so two sources are never granted at once.
// PARAMETERS
//  MAX_HOLD  8  maximum consecutive granted cycles per owner; legal range 1..15, 0 is illegal
//  HOLD_W    4  width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk      in   1  single clock; all state updates on the rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   4  request, one bit per requester; level, held until served
//  done     in   4  owner release strobe; only done[owner] is honoured
//  s0       out  1  mux select LSB, registered
//  s1       out  1  mux select MSB, registered
//  gnt      out  4  one-hot grant, registered; all-zero when idle
//  busy     out  1  high while any gnt bit is set
//  timeout  out  1  one-cycle pulse; owner was released by MAX_HOLD
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=IDLE, gnt=0000, busy=0, timeout=0, {s1,s0}=00, hold_cnt=0, ptr=3.
//   - ptr=3 gives requester 0 first priority. Reset overrides every other input, including mid-grant.
//  States: IDLE, BUSY.
//  IDLE:
//   - If req!=0, scan (ptr+1)%4, (ptr+2)%4, ... and pick the first set bit k.
//   - At the next edge: gnt=onehot(k), {s1,s0}=k, busy=1, ptr=k, hold_cnt=0, state=BUSY.
//   - Latency from req to gnt is 1 cycle.
//   - If req==0, stay in IDLE. s1:s0 hold their last value while idle.
//  BUSY (owner k):
//   - Each cycle, evaluate in priority order:
//     a. If done[k]=1 or req[k]=0: release, timeout stays 0.
//     b. Else if hold_cnt==MAX_HOLD-1: release and set timeout=1 for the following cycle.
//     c. Else hold_cnt = hold_cnt+1.
//   - Release: at the edge, gnt=0000, busy=0, state=IDLE; s1:s0 unchanged.
//   - An owner is granted for at most MAX_HOLD consecutive cycles.
//   - done/req changes on non-owner bits have no effect during BUSY.
//   - New requests are only considered in IDLE, so there is always ≥1 idle cycle between grants.
//  Simultaneous events:
//   - done[k] and hold limit in the same cycle: treated as done, timeout=0.
//   - rst together with anything: reset wins.
//  Fairness:
//   - ptr is the last owner; with all four requesting, grants rotate 0,1,2,3,0...
//   - A timed-out owner that still requests goes to the back of the rotation.
//   - A sole requester is re-granted after one idle cycle.
//  timeout is high only in the IDLE cycle immediately after a hold-limit release; otherwise 0.
//  Invariants: gnt is zero or one-hot; busy == |gnt; when gnt!=0, {s1,s0}==index(gnt).
// TESTING (MAX_HOLD=8; bench drives m41 with the s0/s1 outputs and checks the mux out)
//  1 Reset: rst=1 for 2 cycles with req=1111, done=1111
//    -> gnt=0000, busy=0, {s1,s0}=00, timeout=0 throughout.
//  2 Single request: req=0100 set at cycle 0
//    -> cycle 1: gnt=0100, {s1,s0}=10, mux out==c.
//    -> done[2] pulsed in cycle 4 -> cycle 5: gnt=0000, busy=0.
//  3 Rotation: req=1111 held, done[owner] pulsed in each owner's first granted cycle
//    -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//  4 Timeout: req=0001 held, done=0
//    -> gnt=0001 for exactly 8 cycles, then 1 idle cycle with timeout=1, then gnt=0001 again.
//  5 done[0] asserted in the 8th granted cycle
//    -> release happens at the same point as test 4 but timeout stays 0.
//    -> done[1] pulsed while 0 owns the grant is ignored.
//  6 rst=1 in the 3rd granted cycle of requester 3
//    -> next cycle gnt=0000, {s1,s0}=00, ptr reset, so requester 0 wins next with req=1001.

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// mux41_rr_arbiter: round-robin owner of a shared 4:1 mux, one dead cycle between grants.
module m41 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         s0,
  input  logic         s1,
  output logic [W-1:0] y
);
  assign y = s1 ? (s0 ? d : c) : (s0 ? b : a);
endmodule

module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       s0,
  output logic       s1,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d, ptr_q, ptr_d, pick;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              to_q, to_d, rel;
  always_comb begin
    pick = ptr_q;
    // descending scan so the slot nearest after ptr is the one left in pick
    for (int i = 4; i >= 1; i--)
      if (req[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    rel     = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = BUSY;
        gnt_d   = 4'b0001 << pick;
        sel_d   = pick;
        ptr_d   = pick;
        cnt_d   = '0;
      end
    end else begin
      // sel_q is the owner index while BUSY
      rel  = done[sel_q] || !req[sel_q] || cnt_q == HOLD_W'(MAX_HOLD - 1);
      to_d = !(done[sel_q] || !req[sel_q]) && cnt_q == HOLD_W'(MAX_HOLD - 1);
      cnt_d = rel ? cnt_q : cnt_q + 1'b1;
      state_d = rel ? IDLE : BUSY;
      gnt_d   = rel ? 4'b0000 : gnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb_mux41_rr_arbiter: directed scoreboard bench for the arbiter driving a shared m41.
module tb_mux41_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic       s0, s1, busy, timeout;
  logic [3:0] gnt;
  logic [7:0] y;
  logic [7:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int         compared = 0;
  int         mismatched = 0;
  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
  } exp_t;
  exp_t sbq[$];

  mux41_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .s0(s0), .s1(s1), .gnt(gnt), .busy(busy), .timeout(timeout)
  );
  m41 #(.W(8)) mux (
    .a(dat[0]), .b(dat[1]), .c(dat[2]), .d(dat[3]), .s0(s0), .s1(s1), .y(y)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] dn, input string tag,
                     input logic [3:0] eg, input logic [1:0] es, input logic et);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; done = dn;
    sbq.push_back('{tag, eg, es, et});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    compared++;
    assert (gnt === e.gnt) else begin
      mismatched++; $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
    end
    compared++;
    assert (busy === |e.gnt) else begin
      mismatched++; $error("FAIL %s busy: got %b expected %b", e.tag, busy, |e.gnt);
    end
    compared++;
    assert (timeout === e.to) else begin
      mismatched++; $error("FAIL %s timeout: got %b expected %b", e.tag, timeout, e.to);
    end
    compared++;
    assert ({s1, s0} === e.sel) else begin
      mismatched++; $error("FAIL %s sel: got %b expected %b", e.tag, {s1, s0}, e.sel);
    end
    compared++;
    assert (y === dat[e.sel]) else begin
      mismatched++; $error("FAIL %s mux_y: got %h expected %h", e.tag, y, dat[e.sel]);
    end
  endtask

  initial begin
    cyc(1, 4'b1111, 4'b1111, "rst0", 4'b0000, 2'b00, 0);
    cyc(1, 4'b1111, 4'b1111, "rst1", 4'b0000, 2'b00, 0);
    cyc(0, 4'b0100, 4'b0000, "single_g1", 4'b0100, 2'b10, 0);
    cyc(0, 4'b0100, 4'b0000, "single_g2", 4'b0100, 2'b10, 0);
    cyc(0, 4'b0100, 4'b0000, "single_g3", 4'b0100, 2'b10, 0);
    cyc(0, 4'b0100, 4'b0000, "single_g4", 4'b0100, 2'b10, 0);
    cyc(0, 4'b0100, 4'b0100, "single_rel", 4'b0000, 2'b10, 0);
    cyc(0, 4'b0000, 4'b0000, "single_idle", 4'b0000, 2'b10, 0);
    cyc(1, 4'b0000, 4'b0000, "rst_ptr", 4'b0000, 2'b00, 0);
    cyc(0, 4'b1111, 4'b0000, "rot_g0", 4'b0001, 2'b00, 0);
    cyc(0, 4'b1111, 4'b0001, "rot_r0", 4'b0000, 2'b00, 0);
    cyc(0, 4'b1111, 4'b0000, "rot_g1", 4'b0010, 2'b01, 0);
    cyc(0, 4'b1111, 4'b0010, "rot_r1", 4'b0000, 2'b01, 0);
    cyc(0, 4'b1111, 4'b0000, "rot_g2", 4'b0100, 2'b10, 0);
    cyc(0, 4'b1111, 4'b0100, "rot_r2", 4'b0000, 2'b10, 0);
    cyc(0, 4'b1111, 4'b0000, "rot_g3", 4'b1000, 2'b11, 0);
    cyc(0, 4'b1111, 4'b1000, "rot_r3", 4'b0000, 2'b11, 0);
    cyc(0, 4'b1111, 4'b0000, "rot_wrap", 4'b0001, 2'b00, 0);
    cyc(0, 4'b0000, 4'b0000, "rot_drop", 4'b0000, 2'b00, 0);
    for (int i = 0; i < 8; i++) cyc(0, 4'b0001, 4'b0000, $sformatf("to_g%0d", i + 1), 4'b0001, 2'b00, 0);
    cyc(0, 4'b0001, 4'b0000, "to_pulse", 4'b0000, 2'b00, 1);
    cyc(0, 4'b0001, 4'b0000, "to_regrant", 4'b0001, 2'b00, 0);
    cyc(0, 4'b0001, 4'b0000, "dn_g2", 4'b0001, 2'b00, 0);
    cyc(0, 4'b0001, 4'b0010, "dn_other", 4'b0001, 2'b00, 0);
    for (int i = 4; i <= 8; i++) cyc(0, 4'b0001, 4'b0000, $sformatf("dn_g%0d", i), 4'b0001, 2'b00, 0);
    cyc(0, 4'b0001, 4'b0001, "dn_at_limit", 4'b0000, 2'b00, 0);
    cyc(0, 4'b0000, 4'b0000, "dn_idle", 4'b0000, 2'b00, 0);
    cyc(0, 4'b1000, 4'b0000, "r3_g1", 4'b1000, 2'b11, 0);
    cyc(0, 4'b1000, 4'b0000, "r3_g2", 4'b1000, 2'b11, 0);
    cyc(0, 4'b1000, 4'b0000, "r3_g3", 4'b1000, 2'b11, 0);
    cyc(1, 4'b1001, 4'b0000, "mid_rst", 4'b0000, 2'b00, 0);
    cyc(0, 4'b1001, 4'b0000, "post_rst_g0", 4'b0001, 2'b00, 0);
    cyc(0, 4'b1001, 4'b0001, "post_rst_r0", 4'b0000, 2'b00, 0);
    cyc(0, 4'b1001, 4'b0000, "post_rst_g3", 4'b1000, 2'b11, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
